adam_aes_decipher_iterative: RTL and testbench
==============================================

// Module: adam_aes_decipher_iterative
// PURPOSE
//   Iterative AES-128 inverse cipher (FIPS-197 InvCipher) for the AES peripheral.
//   Decrypts one 128-bit block in 11 cycles, one round per cycle.
//   Consumes the round keys produced by the key expansion unit (rk[0]..rk[10]).
//   Sits beside the encipher under the AES core controller, which drives it when encdec=0.
// PARAMETERS
//   NR      10   number of rounds (AES-128 only; other values unsupported)
// PORTS
//   clk             in   1     clock; all logic on posedge
//   reset           in   1     synchronous, active-high reset
//   start           in   1     request decryption of block; sampled when ready=1
//   ready           out  1     core idle and able to accept start
//   valid           out  1     one-cycle pulse: result holds a new plaintext
//   key_err         out  1     one-cycle pulse: operation aborted, key_ready dropped
//   key_ready       in   1     round_keys are valid; must stay high for the whole operation
//   block           in   128   ciphertext; sampled only in the start-accept cycle
//   round_keys_flat in   1408  rk[i] = round_keys_flat[128*i+127 -: 128], i=0..10
//   result          out  128   plaintext; registered, held until the next accepted start
// BEHAVIOUR
//   Reset: state=IDLE, ready=1, valid=0, key_err=0, result=0, round counter=0, state reg=0.
//   Accept: start & ready & key_ready in cycle T. start while !key_ready or busy is ignored.
//   Datapath (s = 128-bit state reg, byte 0 = bits [127:120], column-major per FIPS-197):
//     IDLE  -> on accept: s <= block ^ rk[10]; rnd <= 9; ready <= 0; go ROUND.
//     ROUND -> s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[rnd]); rnd <= rnd-1;
//              when rnd==1 go FINAL (9 ROUND cycles: rnd = 9..1).
//     FINAL -> result <= InvSubBytes(InvShiftRows(s)) ^ rk[0]; valid <= 1; ready <= 1; go IDLE.
//   Timing: accept at T -> valid=1 and result updated at T+11; ready=0 for T+1..T+10.
//     ready returns to 1 in the same cycle valid rises. A start in that cycle is accepted,
//     so the sustained rate is one block per 11 cycles.
//   valid is exactly one cycle wide. result changes only in the FINAL->IDLE transition.
//   Key loss: key_ready=0 in any ROUND/FINAL cycle -> abort to IDLE. key_err=1 for one cycle.
//     ready=1 next cycle, valid stays 0, result keeps its previous value.
//   Round keys are not captured: they are read combinationally from round_keys_flat each cycle.
//   Reset asserted mid-operation -> full reset values next cycle; no valid or key_err pulse.
//   rnd is a 4-bit down-counter and never leaves the range 0..9.
//   Illegal state encoding -> IDLE with reset output values.
//   InvSubBytes: inverse S-box as a combinational 256-entry function, 16 instances.
//   InvMixColumns: GF(2^8) multiply by {0e,0b,0d,09} via xtime chains, poly 0x11b.
//   InvShiftRows: row r rotated right by r bytes.
// TESTING
//   1 FIPS-197 C.1: key 000102..0f expanded (rk[10]=13111d7fe3944a17f307a78b4d2b30c5),
//     block=69c4e0d86a7b0430d8cdb78070b4c55a, start -> valid at T+11,
//     result=00112233445566778899aabbccddeeff.
//   2 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block=3925841d02dc09fbdc118597196a0b32
//     -> result=3243f6a8885a308d313198a2e0370734.
//   3 Back-to-back: start again in the valid cycle with the App. B block -> second valid exactly
//     11 cycles later. start pulses mid-operation are ignored: no extra valid, same latency.
//   4 start while key_ready=0 -> ready stays 1, no valid within 20 cycles, result unchanged.
//   5 Drop key_ready at T+5 -> key_err pulse at T+6, ready=1, no valid, result unchanged.
//   6 Assert reset at T+4 for one cycle -> next cycle ready=1, valid=0, result=0;
//     a fresh C.1 run then passes.
//   All runs: check valid is 1 cycle wide and ready is low throughout every busy window.

Source files
------------

// File: rtl/adam_aes_decipher_iterative.sv
`timescale 1ns/1ps
// adam_aes_decipher_iterative
//   Iterative AES-128 inverse cipher. One block is decrypted in 11 cycles:
//   the initial AddRoundKey(rk[10]) on accept, nine full inverse rounds and
//   one final round without InvMixColumns. Round keys are read directly
//   from round_keys_flat every cycle and are not captured.
// Ports
//   clk             clock, all logic on the rising edge
//   reset           synchronous active-high reset
//   start           decrypt request, taken when ready & key_ready
//   ready           idle and able to accept start
//   valid           one-cycle pulse, result holds a new plaintext
//   key_err         one-cycle pulse, operation aborted because key_ready fell
//   key_ready       round keys valid, must stay high while busy
//   block           ciphertext, sampled only in the accept cycle
//   round_keys_flat rk[i] = round_keys_flat[128*i+127 -: 128], i = 0..NR
//   result          plaintext, held until the next completed operation
module adam_aes_decipher_iterative #(
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    ready,
  output logic                    valid,
  output logic                    key_err,
  input  logic                    key_ready,
  input  logic [127:0]            block,
  input  logic [128*(NR+1)-1:0]   round_keys_flat,
  output logic [127:0]            result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Inverse S-box, entry x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    // 2047 - 8*b == {~b, 3'b111}
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; products built from x2/x4/x8 chains.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t       state_reg;
  logic [3:0]   rnd_reg;
  logic [127:0] s_reg;
  logic [127:0] result_reg;
  logic         ready_reg;
  logic         valid_reg;
  logic         key_err_reg;

  logic [127:0] rk [0:NR];
  logic [127:0] rk_sel;
  logic [127:0] isb_state;   // InvSubBytes(InvShiftRows(s))
  logic [127:0] ark_state;   // ... ^ rk[rnd]
  logic [127:0] round_state; // InvMixColumns(...)

  genvar gi;

  for (gi = 0; gi <= NR; gi++) begin : g_rk
    assign rk[gi] = round_keys_flat[128*gi+127 -: 128];
  end

  // rnd is 0 in FINAL, so the same selector serves both round kinds.
  assign rk_sel = rk[rnd_reg];

  // Output byte (row r, col c) comes from input byte (row r, col c-r mod 4).
  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);
    assign isb_state[127-8*gi -: 8] = inv_sbox(s_reg[127-8*SRC -: 8]);
  end

  assign ark_state = isb_state ^ rk_sel;

  for (gi = 0; gi < 4; gi++) begin : g_col
    assign round_state[127-32*gi -: 32] = inv_mix_col(ark_state[127-32*gi -: 32]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rnd_reg     <= 4'd0;
      s_reg       <= '0;
      result_reg  <= '0;
      ready_reg   <= 1'b1;
      valid_reg   <= 1'b0;
      key_err_reg <= 1'b0;
    end else begin
      valid_reg   <= 1'b0;
      key_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && ready_reg && key_ready) begin
            s_reg     <= block ^ rk[NR];
            rnd_reg   <= 4'(NR - 1);
            ready_reg <= 1'b0;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          if (!key_ready) begin
            state_reg   <= IDLE;
            rnd_reg     <= 4'd0;
            ready_reg   <= 1'b1;
            key_err_reg <= 1'b1;
          end else begin
            s_reg   <= round_state;
            rnd_reg <= rnd_reg - 4'd1;
            if (rnd_reg == 4'd1) state_reg <= FINAL;
          end
        end
        FINAL: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          rnd_reg   <= 4'd0;
          if (!key_ready) begin
            key_err_reg <= 1'b1;
          end else begin
            result_reg <= ark_state;
            valid_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          rnd_reg     <= 4'd0;
          s_reg       <= '0;
          result_reg  <= '0;
          ready_reg   <= 1'b1;
          valid_reg   <= 1'b0;
          key_err_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_reg;
  assign valid   = valid_reg;
  assign key_err = key_err_reg;
  assign result  = result_reg;

endmodule

// File: tb/tb_adam_aes_decipher_iterative.sv
`timescale 1ns/1ps
// tb_adam_aes_decipher_iterative
//   Bench for the iterative AES-128 decipher. The reference is a forward
//   AES-128 cipher built from first principles (S-box derived from the
//   GF(2^8) inverse and affine map, FIPS key schedule); random plaintexts are
//   enciphered by the model and the DUT must recover them. Known-answer
//   vectors, back-to-back starts, key loss and mid-run reset are covered.
module tb_adam_aes_decipher_iterative;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           ready;
  logic           valid;
  logic           key_err;
  logic           key_ready;
  logic [127:0]   block;
  logic [1407:0]  round_keys_flat;
  logic [127:0]   result;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rk_m [11];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  adam_aes_decipher_iterative #(.NR(10)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ready           (ready),
    .valid           (valid),
    .key_err         (key_err),
    .key_ready       (key_ready),
    .block           (block),
    .round_keys_flat (round_keys_flat),
    .result          (result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      round_keys_flat[128*r+127 -: 128] = rk_m[r];
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [127:0] out;
    for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ rk_m[0][127-8*k -: 8];
    for (int round = 1; round <= 10; round++) begin
      for (int k = 0; k < 16; k++) tmp[k] = sbox[st[k]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          st[r+4*c] = tmp[r+4*((c+r)%4)];
      if (round < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) tmp[r] = st[4*c+r];
          st[4*c+0] = gmul(tmp[0], 8'h02) ^ gmul(tmp[1], 8'h03) ^ tmp[2] ^ tmp[3];
          st[4*c+1] = tmp[0] ^ gmul(tmp[1], 8'h02) ^ gmul(tmp[2], 8'h03) ^ tmp[3];
          st[4*c+2] = tmp[0] ^ tmp[1] ^ gmul(tmp[2], 8'h02) ^ gmul(tmp[3], 8'h03);
          st[4*c+3] = gmul(tmp[0], 8'h03) ^ tmp[1] ^ tmp[2] ^ gmul(tmp[3], 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) st[k] = st[k] ^ rk_m[round][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) out[127-8*k -: 8] = st[k];
    return out;
  endfunction

  // Called with ready=1; start is raised now and taken at the next edge.
  // Returns in the valid cycle (T+11) with start low.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp_pt,
                           input string tag, input bit noise);
    start = 1'b1;
    block = ct;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      block = {$urandom, $urandom, $urandom, $urandom};
      check($sformatf("%s.busy T+%0d {ready,valid,key_err}", tag, k),
            {ready, valid, key_err}, 3'b000);
    end
    tick();
    start = 1'b0;
    check($sformatf("%s.done {ready,valid,key_err}", tag), {ready, valid, key_err}, 3'b110);
    check($sformatf("%s.result", tag), result, exp_pt);
    $display("[TB] %s ct=%h pt=%h", tag, ct, result);
  endtask

  task automatic check_idle_after(input string tag, input logic [127:0] exp_pt);
    tick();
    check($sformatf("%s.after {ready,valid,key_err}", tag), {ready, valid, key_err}, 3'b100);
    check($sformatf("%s.after result", tag), result, exp_pt);
  endtask

  initial begin
    logic [127:0] key, pt, ct;
    reset = 1'b1;
    start = 1'b0;
    key_ready = 1'b0;
    block = '0;
    round_keys_flat = '0;
    build_sbox();
    repeat (2) tick();
    check("reset {ready,valid,key_err}", {ready, valid, key_err}, 3'b100);
    check("reset result", result, 128'h0);
    reset = 1'b0;
    key_ready = 1'b1;
    tick();

    // FIPS-197 C.1 and App. B known answers
    expand_key(C1_KEY);
    run_block(C1_CT, C1_PT, "c1", 1'b0);
    check_idle_after("c1", C1_PT);

    expand_key(B_KEY);
    run_block(B_CT, B_PT, "appb", 1'b0);
    // back-to-back: start raised in the valid cycle, mid-run start noise
    run_block(B_CT, B_PT, "b2b", 1'b1);
    check_idle_after("b2b", B_PT);

    // start while key_ready=0 is ignored
    key_ready = 1'b0;
    start = 1'b1;
    block = C1_CT;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("nokey.c%0d {ready,valid,key_err}", k), {ready, valid, key_err}, 3'b100);
    end
    check("nokey result", result, B_PT);
    $display("[TB] nokey result=%h", result);
    start = 1'b0;
    key_ready = 1'b1;
    tick();

    // key_ready dropped during cycle T+5 -> key_err in T+6
    start = 1'b1;
    block = B_CT;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
      check($sformatf("keyloss.busy T+%0d", k), {ready, valid, key_err}, 3'b000);
    end
    key_ready = 1'b0;
    tick();
    check("keyloss T+6 {ready,valid,key_err}", {ready, valid, key_err}, 3'b101);
    check("keyloss result", result, B_PT);
    key_ready = 1'b1;
    check_idle_after("keyloss", B_PT);
    $display("[TB] keyloss result=%h", result);

    // reset asserted in cycle T+4
    expand_key(C1_KEY);
    start = 1'b1;
    block = C1_CT;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreset {ready,valid,key_err}", {ready, valid, key_err}, 3'b100);
    check("midreset result", result, 128'h0);
    reset = 1'b0;
    check_idle_after("midreset", 128'h0);
    $display("[TB] midreset result=%h", result);
    run_block(C1_CT, C1_PT, "c1_again", 1'b0);
    check_idle_after("c1_again", C1_PT);

    // random keys and plaintexts against the forward-cipher model
    for (int n = 0; n < 10; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key);
      ct = encrypt(pt);
      run_block(ct, pt, $sformatf("rnd%0d", n), 1'b1);
      if ($urandom_range(0, 1) == 1) check_idle_after($sformatf("rnd%0d", n), pt);
    end
    check_idle_after("final", pt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
